// File: rtl/sqr_fixed_iter_if.sv
// rtl/sqr_fixed_iter_if.sv - operand/result handshake bundle for the iterative squarer
interface sqr_fixed_iter_if #(
  parameter int WL = 24
);
  logic [WL-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [WL-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  // master drives operands in and accepts results
  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  // slave is the squarer itself
  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/sqr_fixed_iter.sv
// rtl/sqr_fixed_iter.sv - MSB-first shift-add squarer, Q1.(WL-1) in, Q2.(WL-2) out; optional SQR_EARLY_EXIT_EN skips leading zeros
module sqr_fixed_iter #(
  parameter int WL = 24,
  parameter int CW = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             CE,
  output logic             busy,
  sqr_fixed_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t          state;
  logic [WL-1:0]   mcand;
  logic [WL-1:0]   mplier;
  logic [2*WL-1:0] acc;
  logic [CW-1:0]   cnt;

  // Partial product for this iteration: multiplicand when the current multiplier MSB is set
  logic [2*WL-1:0] addend;
  assign addend = mplier[WL-1] ? {{WL{1'b0}}, mcand} : '0;

  // Rounded upper half of the exact product; the +1 cannot wrap since max input squares below all-ones
  logic [WL-1:0] rounded;
  assign rounded = acc[2*WL-1:WL] + {{(WL-1){1'b0}}, acc[WL-1]};

`ifdef SQR_EARLY_EXIT_EN
  // Significant length of the operand: index of its highest set bit plus one, zero for din=0
  logic [CW-1:0] din_len;
  always_comb begin
    din_len = '0;
    for (int i = 0; i < WL; i++) begin
      if (bus.din[i]) din_len = CW'(i + 1);
    end
  end
`endif

  // Control FSM and datapath; everything holds while CE is low
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.din_ready  <= 1'b1;
      busy           <= 1'b0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          if (bus.din_valid && bus.din_ready) begin
            mcand         <= bus.din;
            acc           <= '0;
            bus.din_ready <= 1'b0;
            busy          <= 1'b1;
`ifdef SQR_EARLY_EXIT_EN
            // Leading zeros of the multiplier add nothing, so align its top bit and run only the significant iterations
            mplier <= bus.din << (CW'(WL) - din_len);
            cnt    <= din_len;
            state  <= (din_len == '0) ? ROUND : CALC;
`else
            mplier <= bus.din;
            cnt    <= CW'(WL);
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          acc    <= (acc << 1) + addend;
          mplier <= mplier << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          bus.dout       <= rounded;
          bus.dout_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          // din_ready only returns once the result is gone, keeping a single operation in flight
          if (bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
            bus.din_ready  <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          bus.dout_valid <= 1'b0;
          bus.din_ready  <= 1'b1;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqr_fixed_iter.sv
// tb/tb_sqr_fixed_iter.sv - directed self-checking bench for sqr_fixed_iter
module tb_sqr_fixed_iter;

`ifdef SQR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int WL       = 24;
  localparam int BASE_LAT = WL + 1;

  logic CLK = 1'b0;
  logic nRST;
  logic ce;
  logic busy;

  int checks   = 0;
  int failures = 0;

  sqr_fixed_iter_if #(.WL(WL)) bus ();

  sqr_fixed_iter #(.WL(WL), .CW(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .CE   (ce),
    .busy (busy),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // operand, expected dout, expected latency with early exit
  logic [23:0] vec_din [7] = '{24'h400000, 24'h800000, 24'hFFFFFF, 24'h000C00, 24'h000800, 24'h000000, 24'h000001};
  logic [23:0] vec_exp [7] = '{24'h100000, 24'h400000, 24'hFFFFFE, 24'h000001, 24'h000000, 24'h000000, 24'h000000};
  int          vec_lee [7] = '{24, 25, 25, 13, 13, 1, 2};

  task automatic start_op(input logic [23:0] d, input string name);
    @(negedge CLK);
    checks++;
    if (bus.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s din_ready before accept: got %b expected 1", name, bus.din_ready);
    end
    bus.din       = d;
    bus.din_valid = 1'b1;
    @(posedge CLK);
    #1 bus.din_valid = 1'b0;
  endtask

  // Called just after the accept edge; measures edges until dout_valid, then does the handoff
  task automatic wait_result(input logic [23:0] exp_d, input int exp_lat, input bit tog, input string name);
    int lat = 0;
    bit seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge CLK);
      if (bus.dout_valid === 1'b1) seen = 1'b1;
      else begin
        if (tog) ce = ~ce;
        @(posedge CLK);
        lat++;
      end
    end
    ce = 1'b1;
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d (seen=%0b)", name, lat, exp_lat, seen);
    end
    checks++;
    if (bus.dout !== exp_d) begin
      failures++;
      $display("FAIL %s dout: got %h expected %h", name, bus.dout, exp_d);
    end
    checks++;
    if (bus.din_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s din_ready/busy in DONE: got %b/%b expected 0/1", name, bus.din_ready, busy);
    end
    bus.dout_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || busy !== 1'b0 || bus.dout !== exp_d) begin
      failures++;
      $display("FAIL %s after handoff: got valid=%b ready=%b busy=%b dout=%h expected 0 1 0 %h",
               name, bus.dout_valid, bus.din_ready, busy, bus.dout, exp_d);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.dout !== 24'h0 || bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got dout=%h valid=%b ready=%b busy=%b expected 0 0 1 0",
               bus.dout, bus.dout_valid, bus.din_ready, busy);
    end
  endtask

  task automatic test_ce_hold();
    @(negedge CLK);
    ce            = 1'b0;
    bus.din       = 24'h400000;
    bus.din_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (bus.din_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL ce_hold accept: got ready=%b busy=%b expected 1 0", bus.din_ready, busy);
      end
    end
    bus.din_valid = 1'b0;
    ce            = 1'b1;
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 7; i++) begin
      start_op(vec_din[i], $sformatf("vec%0d", i));
      wait_result(vec_exp[i], EE ? vec_lee[i] : BASE_LAT, 1'b0, $sformatf("vec%0d", i));
    end
  endtask

  task automatic test_back_pressure();
    int lat = 0;
    bus.dout_ready = 1'b0;
    start_op(24'h600000, "bp");
    while (bus.dout_valid !== 1'b1 && lat < 200) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    checks++;
    if (lat != (EE ? 24 : BASE_LAT)) begin
      failures++;
      $display("FAIL bp latency: got %0d expected %0d", lat, EE ? 24 : BASE_LAT);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.dout !== 24'h240000 || bus.dout_valid !== 1'b1 || bus.din_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp hold cycle %0d: got dout=%h valid=%b ready=%b expected 240000 1 0",
                 i, bus.dout, bus.dout_valid, bus.din_ready);
      end
      bus.din       = 24'h400000;
      bus.din_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
    end
    bus.dout_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || bus.dout !== 24'h240000) begin
      failures++;
      $display("FAIL bp handoff: got valid=%b ready=%b dout=%h expected 0 1 240000",
               bus.dout_valid, bus.din_ready, bus.dout);
    end
    @(posedge CLK);
    #1 bus.din_valid = 1'b0;
    wait_result(24'h100000, EE ? 24 : BASE_LAT, 1'b0, "bp_pending");
  endtask

  task automatic test_ce_toggle();
    start_op(24'hC00000, "ce_toggle");
    wait_result(24'h900000, 2 * BASE_LAT, 1'b1, "ce_toggle");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge CLK);
    bus.din       = 24'h800000;
    bus.din_valid = 1'b1;
    while (bus.dout_valid !== 1'b1 && n < 100) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (bus.dout_valid !== 1'b1 && n < 100);
    bus.din_valid = 1'b0;
    checks++;
    if (n != WL + 3 || bus.dout !== 24'h400000) begin
      failures++;
      $display("FAIL back_to_back period: got %0d dout=%h expected %0d 400000", n, bus.dout, WL + 3);
    end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || bus.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back idle: got busy=%b ready=%b expected 0 1", busy, bus.din_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit leaked = 1'b0;
    start_op(24'hFFFFFF, "rst_mid");
    repeat (5) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 24'h0 || bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid immediate: got dout=%h valid=%b ready=%b busy=%b expected 0 0 1 0",
               bus.dout, bus.dout_valid, bus.din_ready, busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (bus.dout_valid === 1'b1) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL rst_mid aborted result emitted: got valid=1 expected 0");
    end
    start_op(24'h800000, "rst_recover");
    wait_result(24'h400000, BASE_LAT, 1'b0, "rst_recover");
  endtask

  initial begin
    nRST           = 1'b0;
    ce             = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge CLK);
    test_reset();
    nRST = 1'b1;
    test_ce_hold();
    test_vectors();
    test_back_pressure();
    test_ce_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqr_fixed_iter.md
Name: sqr_fixed_iter

Overview:
- Iterative unsigned fixed-point squarer. It is the inverse operation of the LUT-based square-root unit and is used to close the loop on that unit: dout_sqrt squared must give back din.
- Accepts one Q1.(WL-1) operand per handshake and computes its exact 2WL-bit square with an MSB-first shift-add loop.
- Returns the result rounded to Q2.(WL-2).
- Sits between the square-root output and the verification/normalisation logic, with ready/valid flow control on both sides.

Parameters:
- WL, 24, input word length; input format Q1.(WL-1), output format Q2.(WL-2).
- CW, 5, iteration-counter width; must satisfy 2^CW > WL.

Ports:
- CLK  in  1  clock, rising-edge.
- nRST  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable; when low, all state and outputs hold.
- din  in  WL  operand, unsigned Q1.(WL-1).
- din_valid  in  1  operand valid.
- din_ready  out  1  block can accept an operand.
- dout  out  WL  result, unsigned Q2.(WL-2), round-half-up.
- dout_valid  out  1  result valid.
- dout_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Single clock CLK; nRST asynchronous active-low. Every register updates only on a CLK rising edge with CE=1.
- Reset: state=IDLE; dout=0, dout_valid=0, din_ready=1, busy=0; accumulator, operand register and counter cleared.
- Reset asserted mid-operation aborts immediately. The partial result is discarded and never presented.
- States:
  - IDLE: din_ready=1. On din_valid&din_ready&CE, capture din into mcand and mplier, clear acc (2WL bits), set cnt=WL, go CALC.
  - CALC: each cycle, acc <= (acc<<1) + (mplier[WL-1] ? mcand : 0); mplier <= mplier<<1; cnt <= cnt-1. When cnt==1 on this edge, go ROUND.
  - ROUND: dout <= acc[2WL-1:WL] + acc[WL-1]; go DONE.
  - DONE: dout_valid=1. On dout_ready&CE, drop dout_valid, go IDLE.
- din_ready is 1 only in IDLE. It is not asserted in the same cycle as a DONE handoff, so there is at most one operation in flight.
- Latency, baseline: operand accepted on edge T, dout_valid rises on edge T+WL+1 (visible the cycle after).
- Throughput: one operand per WL+3 cycles when dout_ready is held high.
- Arithmetic: exact product Q2.(2WL-2) held in acc. Output keeps the upper WL bits and adds 1 if acc[WL-1]=1 (round-half-up).
- Rounding-carry overflow cannot occur: maximum input 2-2^-(WL-1) squares to acc[2WL-1:WL] = all-ones minus 1, so +1 never wraps. The bench checks this.
- din=0 produces dout=0.
- dout holds its value after the DONE handoff until the next ROUND.
- CE=0 in any state freezes state, counter, acc and all outputs. A din_valid pulse with CE=0 is not accepted.
- din_valid asserted while busy is ignored; the upstream must hold din/din_valid until din_ready.

Optional Feature:
- Macro SQR_EARLY_EXIT_EN.
- Defined:
  - In IDLE on accept, a leading-zero count of din sets cnt = (index of highest set bit)+1 and pre-shifts mplier left by the leading-zero count. Skipped iterations contribute nothing to acc.
  - If din=0, go directly to ROUND with acc=0.
  - Latency becomes n+1 edges, where n = index of highest set bit + 1 (0 for din=0).
- Undefined: fixed WL iterations; the leading-zero logic is not synthesised.
- Results are bit-identical in both builds.

Test Plan:
- Reset mid-CALC (pulse nRST low asynchronously) -> dout=0, dout_valid=0, din_ready=1 immediately. No result is emitted for the aborted operand.
- din=0x400000 (0.5), dout_ready=1 -> dout=0x100000. Baseline: dout_valid at edge T+25. With SQR_EARLY_EXIT_EN: at T+24.
- din=0x800000 (1.0) -> dout=0x400000. din=0xFFFFFF -> dout=0xFFFFFE (no rounding wrap).
- Rounding: din=0x000C00 -> product 0x900000, dout=0x000001. din=0x000800 -> product 0x400000, dout=0x000000.
- Back-pressure: dout_ready=0 for 10 cycles after dout_valid -> dout/dout_valid stable and din_ready=0 throughout. A din_valid offered meanwhile is accepted only after the handoff.
- CE toggling (CE low every other cycle) during CALC -> identical dout to the CE=1 run, with latency doubled. din=0 under SQR_EARLY_EXIT_EN -> dout=0 at edge T+1.
